// File: rtl/tile_renderer_pkg.sv
// Shared types for the tile renderer: FSM states, connection bit positions
// and the symbolic colour palette with its per-channel on/off mask.
package tile_renderer_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    FILL  = 1'b1
  } fill_state_t;

  localparam int CONN_UP    = 0;
  localparam int CONN_DOWN  = 1;
  localparam int CONN_LEFT  = 2;
  localparam int CONN_RIGHT = 3;

  typedef enum logic [2:0] {
    COL_BLACK  = 3'd0,
    COL_GREEN  = 3'd1,
    COL_RED    = 3'd2,
    COL_YELLOW = 3'd3,
    COL_WHITE  = 3'd4
  } color_t;

  // {r, g, b} channel enables; an enabled channel is driven at full intensity
  function automatic logic [2:0] color_mask(input color_t c);
    case (c)
      COL_GREEN:  color_mask = 3'b010;
      COL_RED:    color_mask = 3'b100;
      COL_YELLOW: color_mask = 3'b110;
      COL_WHITE:  color_mask = 3'b111;
      default:    color_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tile_renderer_row_buffer.sv
// Two banks of per-tile connection masks for one playfield row each.
// One write port (overwrite or OR-merge) and one combinational read port.
module tile_row_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = $clog2(2 * DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_merge,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [IW-1:0]     wr_index;
  logic [IW-1:0]     rd_index;

  assign wr_index = wr_bank ? IW'(DEPTH) + IW'(wr_addr) : IW'(wr_addr);
  assign rd_index = rd_bank ? IW'(DEPTH) + IW'(rd_addr) : IW'(rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index] <= wr_merge ? (mem[wr_index] | wr_data) : wr_data;
    end
  end

  // Read is combinational so the pixel pipeline keeps its single output register
  assign rd_data = mem[rd_index];

endmodule

// File: rtl/tile_renderer.sv
// Pixel colour generator for a tiled snake playfield: buffers the next row's
// segments while the current row is displayed, then paints border/snake/apple.
module tile_renderer
  import tile_renderer_pkg::*;
#(
  parameter int GRID_W       = 16,
  parameter int GRID_H       = 12,
  parameter int TILE_LOG2    = 5,
  parameter int COLOR_BITS   = 2,
  parameter int FLASH_FRAMES = 8,
  localparam int XW          = $clog2(GRID_W + 2),
  localparam int YW          = $clog2(GRID_H + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            px,
  input  logic [9:0]            py,
  input  logic                  visible,
  input  logic                  frame_start,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  input  logic [XW-1:0]         seg_x,
  input  logic [YW-1:0]         seg_y,
  input  logic [3:0]            seg_conn,
  input  logic [XW-1:0]         apple_x,
  input  logic [YW-1:0]         apple_y,
  input  logic                  apple_valid,
  input  logic                  success,
  input  logic                  failure,
  input  logic                  eat,
  input  logic                  colorblind,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b
);

  localparam int AW   = $clog2(GRID_W);
  localparam int TILE = 1 << TILE_LOG2;
  localparam int BAND = 1 << (TILE_LOG2 - 3);

  fill_state_t    state_reg, state_next;
  logic [AW-1:0]  clr_idx_reg, clr_idx_next;
  logic           clr_other_reg, clr_other_next;
  logic           clr_both_reg, clr_both_next;
  logic [YW-1:0]  fill_y_reg;
  logic           disp_bank_reg;
  logic           visible_reg;
  logic [7:0]     flash_reg;

  logic           wr_en, wr_bank, wr_merge;
  logic [AW-1:0]  wr_addr;
  logic [3:0]     wr_data;
  logic [3:0]     entry;

  logic [9:0]     tile_x, tile_y;
  logic [1:0]     reg_x, reg_y;
  logic           swap, in_area, border, playfield, center, apple_hit, edge_hit;
  color_t         color;
  logic [2:0]     mask;

  function automatic logic [1:0] region(input logic [TILE_LOG2-1:0] off);
    if (off < TILE_LOG2'(BAND))             region = 2'd0;
    else if (off >= TILE_LOG2'(TILE - BAND)) region = 2'd2;
    else                                     region = 2'd1;
  endfunction

  assign tile_x = px >> TILE_LOG2;
  assign tile_y = py >> TILE_LOG2;
  assign reg_x  = region(px[TILE_LOG2-1:0]);
  assign reg_y  = region(py[TILE_LOG2-1:0]);

  // Swap on the trailing edge of the last scanline of a tile row
  assign swap = visible_reg && !visible && (py[TILE_LOG2-1:0] == '1);

  tile_row_buffer #(.DEPTH(GRID_W), .DATA_W(4)) u_rows (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_merge (wr_merge),
    .rd_bank  (disp_bank_reg),
    .rd_addr  (AW'(tile_x - 10'd1)),
    .rd_data  (entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= CLEAR;
      clr_idx_reg   <= '0;
      clr_other_reg <= 1'b0;
      clr_both_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      clr_idx_reg   <= clr_idx_next;
      clr_other_reg <= clr_other_next;
      clr_both_reg  <= clr_both_next;
    end
  end

  // After reset both banks are wiped; after a swap only the new fill bank
  always_comb begin
    state_next     = state_reg;
    clr_idx_next   = clr_idx_reg;
    clr_other_next = clr_other_reg;
    clr_both_next  = clr_both_reg;
    seg_ready      = 1'b0;
    wr_en          = 1'b0;
    wr_bank        = ~disp_bank_reg;
    wr_addr        = clr_idx_reg;
    wr_data        = '0;
    wr_merge       = 1'b0;
    if (!rst_n) begin
      state_next = CLEAR;
    end else if (swap) begin
      state_next     = CLEAR;
      clr_idx_next   = '0;
      clr_other_next = 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          wr_en   = 1'b1;
          wr_bank = clr_other_reg ? disp_bank_reg : ~disp_bank_reg;
          if (clr_idx_reg == AW'(GRID_W - 1)) begin
            clr_idx_next = '0;
            if (clr_both_reg && !clr_other_reg) begin
              clr_other_next = 1'b1;
            end else begin
              state_next     = FILL;
              clr_other_next = 1'b0;
              clr_both_next  = 1'b0;
            end
          end else begin
            clr_idx_next = clr_idx_reg + 1'b1;
          end
        end
        FILL: begin
          seg_ready = 1'b1;
          if (seg_valid && seg_y == fill_y_reg &&
              seg_x >= XW'(1) && seg_x <= XW'(GRID_W)) begin
            wr_en    = 1'b1;
            wr_addr  = AW'(seg_x - XW'(1));
            wr_data  = seg_conn;
            wr_merge = 1'b1;
          end
        end
        default: state_next = CLEAR;
      endcase
    end
  end

  assign in_area   = tile_x <= 10'(GRID_W + 1) && tile_y <= 10'(GRID_H + 1);
  assign border    = in_area && (tile_x == 10'd0 || tile_x == 10'(GRID_W + 1) ||
                                 tile_y == 10'd0 || tile_y == 10'(GRID_H + 1));
  assign playfield = in_area && !border;
  assign center    = reg_x == 2'd1 && reg_y == 2'd1;
  assign apple_hit = apple_valid && tile_x == 10'(apple_x) && tile_y == 10'(apple_y);
  assign edge_hit  = (reg_x == 2'd1 && reg_y == 2'd0 && entry[CONN_UP])   ||
                     (reg_x == 2'd1 && reg_y == 2'd2 && entry[CONN_DOWN]) ||
                     (reg_x == 2'd0 && reg_y == 2'd1 && entry[CONN_LEFT]) ||
                     (reg_x == 2'd2 && reg_y == 2'd1 && entry[CONN_RIGHT]);

  always_comb begin
    color = COL_BLACK;
    if (visible && border) begin
      if (flash_reg != 8'd0)        color = COL_YELLOW;
      else if (success && !failure) color = COL_GREEN;
      else if (failure && !success) color = COL_RED;
      else                          color = COL_WHITE;
    end else if (visible && playfield) begin
      if (center && entry != 4'd0) color = COL_GREEN;
      else if (center && apple_hit) color = COL_RED;
      else if (edge_hit)            color = COL_GREEN;
    end
  end

  assign mask = color_mask(color);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_y_reg    <= YW'(1);
      disp_bank_reg <= 1'b0;
      visible_reg   <= 1'b0;
      flash_reg     <= 8'd0;
      r             <= '0;
      g             <= '0;
      b             <= '0;
    end else begin
      visible_reg <= visible;
      if (swap) begin
        disp_bank_reg <= ~disp_bank_reg;
        fill_y_reg    <= (fill_y_reg == YW'(GRID_H + 1)) ? '0 : fill_y_reg + 1'b1;
      end
      if (eat) begin
        flash_reg <= 8'(FLASH_FRAMES);
      end else if (frame_start && flash_reg != 8'd0) begin
        flash_reg <= flash_reg - 8'd1;
      end
      r <= {COLOR_BITS{mask[2]}};
      g <= {COLOR_BITS{colorblind ? mask[0] : mask[1]}};
      b <= {COLOR_BITS{colorblind ? mask[1] : mask[0]}};
    end
  end

endmodule
